// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a MAR-addressed external memory.
// Each access runs IDLE -> ADDR -> DATA -> DONE on a shared 16-bit bus.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [7:0]        rdata,
  output logic [15:0]       bus,
  output logic              mem_mar_we,
  output logic              mem_ram_we,
  input  logic [7:0]        mem_out,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              own_q, own_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              win;

  // Port 1 wins alone, or on a tie when it was not granted last (round-robin).
  always_comb begin
    win = req1 & (~req0 | (~FIXED_PRIO & ~last_q));
  end

  // Next-state logic: latch the winner in IDLE, then walk the fixed sequence.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          own_d   = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (!we_q) rdata_d = mem_out;
        state_d = DONE;
      end
      DONE: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves port 1 as the last grant so port 0 wins first.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    busy       = (state_q != IDLE);
    gnt0       = busy & ~own_q;
    gnt1       = busy & own_q;
    done0      = (state_q == DONE) & ~own_q;
    done1      = (state_q == DONE) & own_q;
    mem_mar_we = (state_q == ADDR);
    mem_ram_we = (state_q == DATA) & we_q;
    rdata      = rdata_q;
    bus        = 16'h0000;
    unique case (state_q)
      ADDR:    bus = 16'(addr_q);
      DATA:    bus = we_q ? {8'h00, wdata_q} : 16'h0000;
      default: bus = 16'h0000;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: width of the address driven on bus; upper bus bits beyond ADDR_W SHALL be 0.
REQ-002 Parameter FIXED_PRIO, default 0: 0 means round-robin arbitration, 1 means port 0 always wins ties.
REQ-003 Port CLK  in  1  system clock; all state SHALL change on its rising edge only.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports req0/req1  in  1  access request per port, held high until the matching done pulse.
REQ-006 Ports we0/we1  in  1  per-port access type: 1 = write, 0 = read.
REQ-007 Ports addr0/addr1  in  ADDR_W  per-port access address.
REQ-008 Ports wdata0/wdata1  in  8  per-port write data.
REQ-009 Ports gnt0/gnt1  out  1  port owns the memory; the two outputs are one-hot or both 0.
REQ-010 Ports done0/done1  out  1  one-cycle completion pulse per port.
REQ-011 Port rdata  out  8  last read data; valid from a read's done pulse until the next read completes.
REQ-012 Port bus  out  16  shared address/data bus to the external memory.
REQ-013 Port mem_mar_we  out  1  load the external address register from bus.
REQ-014 Port mem_ram_we  out  1  write bus[7:0] into external memory.
REQ-015 Port mem_out  in  8  external memory read data, valid in the cycle after MAR load.
REQ-016 Port busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA and DONE, each lasting exactly one cycle except IDLE.
REQ-018 IDLE: when any req is high, the FSM SHALL select a winner, latch its we/addr/wdata, and enter ADDR; with no request it SHALL stay in IDLE.
REQ-019 Arbitration: a single requester SHALL win; on a tie, port 0 SHALL win when FIXED_PRIO=1; otherwise the port not granted most recently SHALL win.
REQ-020 ADDR: bus SHALL carry the latched address (zero-extended) and mem_mar_we SHALL be 1; next state is DATA.
REQ-021 DATA, write: bus SHALL be {8'h00, wdata} and mem_ram_we SHALL be 1.
REQ-022 DATA, read: mem_ram_we SHALL be 0, bus SHALL be 0, and mem_out SHALL be captured into rdata at the cycle end; next state is DONE.
REQ-023 DONE: done of the winner SHALL be 1 for exactly this cycle, the last-grant record SHALL update, and the next state is IDLE.
REQ-024 The gnt of the winner SHALL be high in ADDR, DATA and DONE and low in IDLE.
REQ-025 Latency: a request first seen in IDLE at edge N SHALL give ADDR in cycle N+1, DATA in N+2 and done in N+3; back-to-back accesses are therefore 4 cycles apart.
REQ-026 Outside ADDR and DATA, bus, mem_mar_we and mem_ram_we SHALL be 0; at most one of mem_mar_we and mem_ram_we SHALL be high in any cycle.
REQ-027 Port inputs that change after the IDLE latch SHALL NOT affect the transaction in flight.
REQ-028 Dropping req mid-transaction SHALL NOT abort it; the transaction SHALL complete and done SHALL still pulse.
REQ-029 A request that arrives while busy SHALL wait and be arbitrated at the next IDLE; it SHALL NOT be lost.
REQ-030 A req still high in the DONE cycle SHALL be eligible again at the following IDLE, subject to REQ-019.
REQ-031 Addresses 16'hFFFF and 16'h0000 SHALL pass unmodified; there SHALL be no wrap or auto-increment.

Reset
REQ-032 While rst_n=0, the FSM SHALL be forced immediately to IDLE and all outputs SHALL be 0, including rdata=8'h00.
REQ-033 After reset, the last-grant record SHALL indicate port 1, so port 0 wins the first tie.
REQ-034 A reset asserted in ADDR or DATA SHALL abort the access: no done pulse, and mem_ram_we SHALL drop asynchronously.
REQ-035 The first arbitration SHALL occur on the first rising CLK edge after rst_n rises.

Verification
REQ-036 Port 0 writes 8'hA5 to 16'h0010 → ADDR: bus=16'h0010 with mar_we=1; DATA: bus=16'h00A5 with ram_we=1; done0 in cycle N+3.
REQ-037 Port 1 reads 16'h0010 from a memory model holding 8'hA5 → rdata=8'hA5 at done1, and ram_we is never 1.
REQ-038 req0 and req1 high continuously with FIXED_PRIO=0 → grants alternate 0,1,0,1 and each done arrives 4 cycles after the previous one.
REQ-039 Same stimulus with FIXED_PRIO=1 → port 0 wins every tie and port 1 is starved; the bench checks the fixed-priority mode.
REQ-040 rst_n pulsed low during DATA of a write → mem_ram_we falls without waiting for a clock edge, no done pulse, state returns to IDLE, and port 0 wins the next tie.
REQ-041 req1 dropped during ADDR and addr1 changed → the original address completes, done1 pulses once, and the FSM returns to IDLE.
